// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: load/store unit bus controller.
// Takes a memory op (store/load, funct3 width code, byte address, store data)
// and runs one request/grant/response transaction on the data bus. It steers
// byte lanes for stores, sign/zero-extends loads, and returns one-cycle
// done_o/err_o pulses so the core can stall around the op.
//
// Ports:
//   clk_i, rst_i                 clock (rising edge), synchronous active-high reset
//   req_i, mem_wren_i, funct3_i  op start (sampled in IDLE), store/load, width code
//   addr_i, st_data_i            byte address, store data
//   ld_data_o                    extended load result (held until next good load)
//   done_o, err_o, busy_o        completion pulse, error pulse, not-idle
//   bus_req_o .. bus_be_o        bus request and request fields
//   bus_gnt_i, bus_rvalid_i      grant, read data valid
//   bus_rdata_i                  read data word
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for req_i
// REQ     | bus_req_o high, waiting for bus_gnt_i
// WAIT    | load granted, waiting for bus_rvalid_i
// DONE    | done_o pulse
// ERR     | done_o + err_o pulse (misalign, illegal funct3, timeout)

module lsu_bus_ctrl #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        mem_wren_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] st_data_i,
   output logic [31:0] ld_data_o,
   output logic        done_o,
   output logic        err_o,
   output logic        busy_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   output logic [3:0]  bus_be_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   // Counter starts at 0 on entry, so the last allowed waiting cycle is TIMEOUT_CYC-1.
   localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   state_t        state, state_nxt;
   logic [CW-1:0] tmo_cnt;
   logic          tmo_hit;
   logic [2:0]    f3_q;
   logic [1:0]    off_q;

   logic          f3_legal, aligned, op_ok;
   logic [3:0]    be_new;
   logic [31:0]   wdata_new;
   logic [31:0]   rd_shift;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;
   logic [31:0]   ld_ext;

   // Request decode from the live inputs (only used in IDLE)
   always_comb begin
      f3_legal = 1'b0;
      aligned  = 1'b1;
      be_new   = 4'b1111;
      wdata_new = st_data_i;
      if (mem_wren_i)
         f3_legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
      else
         f3_legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                    (funct3_i == 3'b100) || (funct3_i == 3'b101);
      case (funct3_i[1:0])
         2'b00: begin
            be_new    = 4'b0001 << addr_i[1:0];
            wdata_new = {4{st_data_i[7:0]}};
         end
         2'b01: begin
            aligned   = ~addr_i[0];
            be_new    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{st_data_i[15:0]}};
         end
         default: begin
            aligned   = (addr_i[1:0] == 2'b00);
            be_new    = 4'b1111;
            wdata_new = st_data_i;
         end
      endcase
      op_ok = f3_legal && aligned;
   end

   // Load extraction from the latched width and byte offset
   always_comb begin
      rd_shift = bus_rdata_i >> {off_q, 3'b000};
      rd_byte  = rd_shift[7:0];
      rd_half  = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
      case (f3_q)
         3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
         3'b100:  ld_ext = {24'h0, rd_byte};
         3'b101:  ld_ext = {16'h0, rd_half};
         default: ld_ext = bus_rdata_i;
      endcase
   end

   assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_cnt == TMO_LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req_i) state_nxt = op_ok ? ST_REQ : ST_ERR;
         ST_REQ: begin
            if (bus_gnt_i)    state_nxt = bus_we_o ? ST_DONE : ST_WAIT;
            else if (tmo_hit) state_nxt = ST_ERR;
         end
         ST_WAIT: begin
            if (bus_rvalid_i) state_nxt = ST_DONE;
            else if (tmo_hit) state_nxt = ST_ERR;
         end
         ST_DONE: state_nxt = ST_IDLE;
         ST_ERR:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus_req_o = (state == ST_REQ);
      busy_o    = (state != ST_IDLE);
      done_o    = (state == ST_DONE) || (state == ST_ERR);
      err_o     = (state == ST_ERR);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Wait counter restarts whenever the state changes, so it counts cycles spent in REQ or WAIT
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tmo_cnt <= '0;
      end else if (state_nxt != state) begin
         tmo_cnt <= '0;
      end else if ((state == ST_REQ) || (state == ST_WAIT)) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   // Bus fields are only loaded for ops that will actually reach the bus
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         f3_q        <= '0;
         off_q       <= '0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_wdata_o <= '0;
         bus_be_o    <= '0;
         ld_data_o   <= '0;
      end else begin
         if ((state == ST_IDLE) && req_i) begin
            f3_q  <= funct3_i;
            off_q <= addr_i[1:0];
            if (op_ok) begin
               bus_we_o    <= mem_wren_i;
               bus_addr_o  <= {addr_i[31:2], 2'b00};
               bus_wdata_o <= wdata_new;
               bus_be_o    <= be_new;
            end
         end
         if ((state == ST_WAIT) && bus_rvalid_i)
            ld_data_o <= ld_ext;
      end
   end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
module tb_lsu_bus_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic        mem_wren_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i;
   logic [31:0] st_data_i;
   logic [31:0] ld_data_o;
   logic        done_o, err_o, busy_o;
   logic        bus_req_o, bus_we_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic [3:0]  bus_be_o;
   logic        bus_gnt_i, bus_rvalid_i;
   logic [31:0] bus_rdata_i;

   int n_checks = 0;
   int n_errors = 0;

   lsu_bus_ctrl #(.TIMEOUT_CYC(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .mem_wren_i(mem_wren_i),
      .funct3_i(funct3_i), .addr_i(addr_i), .st_data_i(st_data_i),
      .ld_data_o(ld_data_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_gnt_i(bus_gnt_i),
      .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data);
      req_i      = 1'b1;
      mem_wren_i = we;
      funct3_i   = f3;
      addr_i     = addr;
      st_data_i  = data;
      tick();
      req_i = 1'b0;
   endtask

   task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
      start_op(1'b1, f3, addr, data);
      check({tag, " req"},   bus_req_o, 1);
      check({tag, " we"},    bus_we_o, 1);
      check({tag, " addr"},  bus_addr_o, exp_addr);
      check({tag, " be"},    bus_be_o, exp_be);
      check({tag, " wdata"}, bus_wdata_o, exp_wdata);
      check({tag, " done1"}, done_o, 0);
      bus_gnt_i = 1'b1;
      tick();
      bus_gnt_i = 1'b0;
      check({tag, " done"},  done_o, 1);
      check({tag, " err"},   err_o, 0);
      check({tag, " req2"},  bus_req_o, 0);
      tick();
      check({tag, " done3"}, done_o, 0);
      check({tag, " busy3"}, busy_o, 0);
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_ld);
      start_op(1'b0, f3, addr, 32'h0);
      check({tag, " req"},  bus_req_o, 1);
      check({tag, " we"},   bus_we_o, 0);
      check({tag, " addr"}, bus_addr_o, exp_addr);
      check({tag, " be"},   bus_be_o, exp_be);
      bus_gnt_i = 1'b1;
      tick();
      bus_gnt_i = 1'b0;
      check({tag, " wait req"},  bus_req_o, 0);
      check({tag, " wait done"}, done_o, 0);
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = rdata;
      tick();
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = 32'h0;
      check({tag, " done"}, done_o, 1);
      check({tag, " err"},  err_o, 0);
      check({tag, " ld"},   ld_data_o, exp_ld);
      tick();
      check({tag, " idle"}, busy_o, 0);
   endtask

   task automatic do_err(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] exp_ld);
      start_op(we, f3, addr, 32'h0);
      check({tag, " done"}, done_o, 1);
      check({tag, " err"},  err_o, 1);
      check({tag, " req"},  bus_req_o, 0);
      check({tag, " ld"},   ld_data_o, exp_ld);
      tick();
      check({tag, " done2"}, done_o, 0);
      check({tag, " err2"},  err_o, 0);
      check({tag, " req2"},  bus_req_o, 0);
      check({tag, " busy2"}, busy_o, 0);
   endtask

   initial begin
      rst_i = 1'b1;
      req_i = 1'b0;
      mem_wren_i = 1'b0;
      funct3_i = 3'b000;
      addr_i = 32'h0;
      st_data_i = 32'h0;
      bus_gnt_i = 1'b0;
      bus_rvalid_i = 1'b0;
      bus_rdata_i = 32'h0;
      tick();
      tick();
      rst_i = 1'b0;
      check("rst busy", busy_o, 0);
      check("rst req",  bus_req_o, 0);
      check("rst done", done_o, 0);
      check("rst err",  err_o, 0);
      check("rst ld",   ld_data_o, 0);
      check("rst addr", bus_addr_o, 0);
      check("rst be",   bus_be_o, 0);

      do_store("SW", 3'b010, 32'h100, 32'hDEADBEEF, 32'h100, 4'b1111, 32'hDEADBEEF);
      do_store("SB", 3'b000, 32'h103, 32'h000000A5, 32'h100, 4'b1000, 32'hA5A5A5A5);
      do_store("SH", 3'b001, 32'h102, 32'h00001234, 32'h100, 4'b1100, 32'h12341234);

      do_load("LB",  3'b000, 32'h202, 32'h12F45678, 32'h200, 4'b0100, 32'hFFFFFFF4);
      do_load("LBU", 3'b100, 32'h202, 32'h12F45678, 32'h200, 4'b0100, 32'h000000F4);
      do_load("LH",  3'b001, 32'h202, 32'h12F45678, 32'h200, 4'b1100, 32'h000012F4);
      do_load("LHU", 3'b101, 32'h200, 32'h1234F678, 32'h200, 4'b0011, 32'h0000F678);
      do_load("LW",  3'b010, 32'h200, 32'h12F45678, 32'h200, 4'b1111, 32'h12F45678);

      do_err("LW mis",  1'b0, 3'b010, 32'h102, 32'h12F45678);
      do_err("LH mis",  1'b0, 3'b001, 32'h101, 32'h12F45678);
      do_err("L f3 011", 1'b0, 3'b011, 32'h100, 32'h12F45678);
      do_err("S f3 100", 1'b1, 3'b100, 32'h100, 32'h12F45678);

      // Timeout: gnt withheld, bus_req_o high for exactly 4 cycles
      start_op(1'b1, 3'b010, 32'h300, 32'h55AA55AA);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("tmo req c%0d", i), bus_req_o, 1);
         check($sformatf("tmo done c%0d", i), done_o, 0);
         tick();
      end
      check("tmo req off", bus_req_o, 0);
      check("tmo done",    done_o, 1);
      check("tmo err",     err_o, 1);
      check("tmo busy",    busy_o, 1);
      tick();
      check("tmo busy off", busy_o, 0);
      check("tmo done off", done_o, 0);

      // Reset while in WAIT; late rvalid must be ignored
      start_op(1'b0, 3'b010, 32'h400, 32'h0);
      bus_gnt_i = 1'b1;
      tick();
      bus_gnt_i = 1'b0;
      check("rstw in wait", busy_o, 1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("rstw busy", busy_o, 0);
      check("rstw req",  bus_req_o, 0);
      check("rstw done", done_o, 0);
      check("rstw err",  err_o, 0);
      check("rstw ld",   ld_data_o, 0);
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 32'hBADBAD00;
      tick();
      bus_rvalid_i = 1'b0;
      check("late rv done", done_o, 0);
      check("late rv ld",   ld_data_o, 0);
      check("late rv busy", busy_o, 0);

      do_load("LW2", 3'b010, 32'h400, 32'hCAFEF00D, 32'h400, 4'b1111, 32'hCAFEF00D);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
- Load/store unit that consumes the memory-op controls produced by control_unit (mem_wren, funct3 width codes LB/LH/LW/LBU/LHU/SB/SH/SW) and the ALU address.
- Runs a multi-cycle request/grant/response transaction on the data bus.
- Performs byte-lane steering and load sign/zero extension.
- Returns write-back data with a one-cycle done pulse so the core can stall around memory ops.

Parameters:
- TIMEOUT_CYC, 255, max cycles waiting for bus_gnt_i or bus_rvalid_i before abort; 0 disables timeout.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- req_i  in  1  start memory op (sampled only in IDLE)
- mem_wren_i  in  1  1=store, 0=load
- funct3_i  in  3  width code instr[14:12]
- addr_i  in  32  byte address from ALU
- st_data_i  in  32  store data (rs2)
- ld_data_o  out  32  extended load result, valid when done_o on a load
- done_o  out  1  one-cycle completion pulse (success or error)
- err_o  out  1  one-cycle pulse with done_o on misalign/illegal funct3/timeout
- busy_o  out  1  high whenever state != IDLE
- bus_req_o  out  1  bus request, held until bus_gnt_i
- bus_we_o  out  1  write enable
- bus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- bus_wdata_o  out  32  lane-replicated store data
- bus_be_o  out  4  byte enables
- bus_gnt_i  in  1  request accepted this cycle
- bus_rvalid_i  in  1  read data valid
- bus_rdata_i  in  32  read data word

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- States: IDLE, REQ, WAIT, DONE, ERR.
- IDLE, req_i=1: latch mem_wren, funct3, addr[1:0], bus fields.
  - Legal and aligned: go REQ.
  - Otherwise: go ERR, no bus activity.
- Legal funct3: loads 000, 001, 010, 100, 101; stores 000, 001, 010. Any other code is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- REQ: bus_req_o=1, bus_* stable. On bus_gnt_i: store goes DONE; load goes WAIT.
- WAIT: bus_req_o=0. On bus_rvalid_i: register the extracted result into ld_data_o, go DONE. rvalid outside WAIT is ignored.
- DONE: done_o=1 for one cycle, then IDLE.
- ERR: done_o=1 and err_o=1 for one cycle, then IDLE. ld_data_o unchanged.
- Timeout: counter clears on entry to REQ/WAIT and increments each cycle there. If it reaches TIMEOUT_CYC before gnt/rvalid: bus_req_o drops, go ERR.
- Lanes:
  - SB: be=1<<addr[1:0], wdata={4{b}}.
  - SH: be=addr[1]?1100:0011, wdata={2{h}}.
  - SW: be=1111.
  - Loads use the same be pattern for their width.
- Load extract: byte/half selected by latched addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- ld_data_o holds the last load value until the next successful load.
- req_i while busy: ignored, no queueing.
- Latency, store with immediate grant: req at cycle 0, bus_req_o at cycle 1, done_o at cycle 2.
- Latency, load with gnt at cycle 1 and rvalid at cycle 2: done_o and ld_data_o at cycle 3.
- Reset in any state: IDLE on next edge; bus_req_o, done_o, err_o, busy_o read 0 after it. Late gnt/rvalid are ignored.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt at first REQ cycle -> bus_addr 0x100, be 1111, we 1, wdata DEADBEEF; done_o at cycle 2, err_o 0.
- SB addr 0x103, data 0x000000A5 -> be 1000, wdata A5A5A5A5. SH addr 0x102, data 0x1234 -> be 1100, wdata 12341234.
- rdata 0x12F45678:
  - LB addr 0x202 -> ld_data FFFFFFF4.
  - LBU addr 0x202 -> 000000F4.
  - LH addr 0x202 -> 000012F4.
  - LW addr 0x200 -> 12F45678.
  - bus_addr 0x200 in every case.
- LW addr 0x102, LH addr 0x101, load funct3 011 -> err_o and done_o one cycle after req; bus_req_o never asserted.
- TIMEOUT_CYC=4, gnt withheld -> bus_req_o high for exactly 4 cycles then 0; done_o and err_o pulse; busy_o falls after.
- Load granted, rst_i pulsed in WAIT, then rvalid -> idle outputs after the reset edge, no done_o, ld_data_o=0. A following LW completes normally.
